// File: rtl/conf_power_sequencer.sv
// Power sequencer for the R&T analog rail: starts regulator sync clocks, enables the rail,
// qualifies power-good, and keeps sync running for a shutdown tail. Optional macro: PWR_PG_SYNC_EN.
module conf_power_sequencer #(
  parameter int unsigned SYNC_DIV     = 50,
  parameter int unsigned SYNC_LEAD    = 64,
  parameter int unsigned PG_FILT      = 8,
  parameter int unsigned RAMP_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       pg_i,
  output logic       pwr_rt_on,
  output logic       pwr_sync_a1,
  output logic       pwr_sync_d1,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int unsigned T_MAX = (SYNC_LEAD > RAMP_TIMEOUT) ? SYNC_LEAD : RAMP_TIMEOUT;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned FW    = $clog2(PG_FILT + 1);
  localparam int unsigned CW    = $clog2(SYNC_DIV);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_SYNC_START = 3'd1,
    S_WAIT_PG    = 3'd2,
    S_RUN        = 3'd3,
    S_SHUTDOWN   = 3'd4,
    S_FAULT      = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [TW-1:0] r_tcnt;
  logic [FW-1:0] r_fcnt;
  logic [CW-1:0] r_cnt;
  logic          r_ph;
  logic          w_pg;
  logic          w_lead_done;
  logic          w_to_done;
  logic          w_filt_done;
  logic          w_run_cur;
  logic          w_run_nxt;

`ifdef PWR_PG_SYNC_EN
  logic r_pg_s1;
  logic r_pg_s2;

  // Two-flop synchronizer for an asynchronous power-good source
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pg_s1 <= 1'b0;
      r_pg_s2 <= 1'b0;
    end else begin
      r_pg_s1 <= pg_i;
      r_pg_s2 <= r_pg_s1;
    end
  end
  assign w_pg = r_pg_s2;
`else
  assign w_pg = pg_i;
`endif

  assign w_lead_done = (r_tcnt == TW'(SYNC_LEAD - 1));
  assign w_to_done   = (r_tcnt == TW'(RAMP_TIMEOUT - 1));
  assign w_filt_done = (r_fcnt == FW'(PG_FILT - 1));
  assign w_run_cur   = r_state inside {S_SYNC_START, S_WAIT_PG, S_RUN, S_SHUTDOWN};
  assign w_run_nxt   = w_nxt inside {S_SYNC_START, S_WAIT_PG, S_RUN, S_SHUTDOWN};
  assign state_o     = r_state;

  // Next state; en_i=0 outranks timeout and pg faults, pg-good outranks timeout
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_OFF:        if (en_i) w_nxt = S_SYNC_START;
      S_SYNC_START: begin
        if (!en_i)            w_nxt = S_SHUTDOWN;
        else if (w_lead_done) w_nxt = S_WAIT_PG;
      end
      S_WAIT_PG: begin
        if (!en_i)                    w_nxt = S_SHUTDOWN;
        else if (w_pg && w_filt_done) w_nxt = S_RUN;
        else if (w_to_done)           w_nxt = S_FAULT;
      end
      S_RUN: begin
        if (!en_i)                     w_nxt = S_SHUTDOWN;
        else if (!w_pg && w_filt_done) w_nxt = S_FAULT;
      end
      S_SHUTDOWN:   if (w_lead_done) w_nxt = S_OFF;
      S_FAULT:      if (!en_i) w_nxt = S_OFF;
      default:      w_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OFF;
      r_tcnt      <= '0;
      r_fcnt      <= '0;
      r_cnt       <= '0;
      r_ph        <= 1'b1;
      pwr_rt_on   <= 1'b0;
      pwr_sync_a1 <= 1'b0;
      pwr_sync_d1 <= 1'b0;
      ready_o     <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      r_state <= w_nxt;

      // Dwell timer only matters in the timed states
      if (w_nxt != r_state || !(r_state inside {S_SYNC_START, S_WAIT_PG, S_SHUTDOWN}))
        r_tcnt <= '0;
      else
        r_tcnt <= r_tcnt + TW'(1);

      // pg filter counts highs while waiting, lows while running
      if (w_nxt != r_state)
        r_fcnt <= '0;
      else if (r_state == S_WAIT_PG)
        r_fcnt <= w_pg ? r_fcnt + FW'(1) : '0;
      else if (r_state == S_RUN)
        r_fcnt <= w_pg ? '0 : r_fcnt + FW'(1);
      else
        r_fcnt <= '0;

      // Sync generator: starts at a1=1 on entry, toggles phase every SYNC_DIV cycles
      if (!w_run_nxt) begin
        r_cnt       <= '0;
        r_ph        <= 1'b1;
        pwr_sync_a1 <= 1'b0;
        pwr_sync_d1 <= 1'b0;
      end else if (!w_run_cur) begin
        r_cnt       <= '0;
        r_ph        <= 1'b1;
        pwr_sync_a1 <= 1'b1;
        pwr_sync_d1 <= 1'b0;
      end else if (r_cnt == CW'(SYNC_DIV - 1)) begin
        r_cnt       <= '0;
        r_ph        <= ~r_ph;
        pwr_sync_a1 <= ~r_ph;
        pwr_sync_d1 <= r_ph;
      end else begin
        r_cnt       <= r_cnt + CW'(1);
        pwr_sync_a1 <= r_ph;
        pwr_sync_d1 <= ~r_ph;
      end

      pwr_rt_on <= (w_nxt == S_WAIT_PG) || (w_nxt == S_RUN);
      ready_o   <= (w_nxt == S_RUN);
      fault_o   <= (w_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_conf_power_sequencer.sv
// Directed plus randomized bench for conf_power_sequencer against a cycle-count reference model.
module tb_conf_power_sequencer;

  localparam int SYNC_DIV     = 4;
  localparam int SYNC_LEAD    = 16;
  localparam int PG_FILT      = 8;
  localparam int RAMP_TIMEOUT = 200;
`ifdef PWR_PG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic       en_i;
  logic       pg_i;
  logic       pwr_rt_on;
  logic       pwr_sync_a1;
  logic       pwr_sync_d1;
  logic       ready_o;
  logic       fault_o;
  logic [2:0] state_o;

  conf_power_sequencer #(
    .SYNC_DIV    (SYNC_DIV),
    .SYNC_LEAD   (SYNC_LEAD),
    .PG_FILT     (PG_FILT),
    .RAMP_TIMEOUT(RAMP_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .pg_i       (pg_i),
    .pwr_rt_on  (pwr_rt_on),
    .pwr_sync_a1(pwr_sync_a1),
    .pwr_sync_d1(pwr_sync_d1),
    .ready_o    (ready_o),
    .fault_o    (fault_o),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tcyc    = 0;

  // Reference model: mode number, samples spent in mode, pg streaks within mode, sync start cycle
  int m_mode = 0;
  int m_age  = 0;
  int m_hi   = 0;
  int m_lo   = 0;
  int m_t0   = -1;
  bit m_pg1  = 1'b0;
  bit m_pg2  = 1'b0;

  function automatic bit sync_on(input int m);
    return (m >= 1) && (m <= 4);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, expv, tcyc);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, tcyc);
    end
  endtask

  // Advance one clock: update the model from the sampled inputs, then compare every output
  task automatic tick();
    int nm;
    bit pgs;
    bit ea1;
    if (rst) begin
      m_mode = 0; m_age = 0; m_hi = 0; m_lo = 0; m_t0 = -1;
      m_pg1 = 1'b0; m_pg2 = 1'b0;
    end else begin
`ifdef PWR_PG_SYNC_EN
      pgs   = m_pg2;
      m_pg2 = m_pg1;
      m_pg1 = pg_i;
`else
      pgs = pg_i;
`endif
      m_age++;
      m_hi = pgs ? m_hi + 1 : 0;
      m_lo = pgs ? 0 : m_lo + 1;
      nm = m_mode;
      case (m_mode)
        0: if (en_i) nm = 1;
        1: if (!en_i) nm = 4; else if (m_age == SYNC_LEAD) nm = 2;
        2: if (!en_i) nm = 4; else if (m_hi == PG_FILT) nm = 3;
           else if (m_age == RAMP_TIMEOUT) nm = 5;
        3: if (!en_i) nm = 4; else if (m_lo == PG_FILT) nm = 5;
        4: if (m_age == SYNC_LEAD) nm = 0;
        default: if (!en_i) nm = 0;
      endcase
      if (nm != m_mode) begin
        if (!sync_on(nm)) m_t0 = -1;
        else if (!sync_on(m_mode)) m_t0 = tcyc + 1;
        m_age = 0; m_hi = 0; m_lo = 0;
        m_mode = nm;
      end
    end
    @(posedge clk);
    #1;
    tcyc++;
    ea1 = (m_t0 >= 0) && ((((tcyc - m_t0) / SYNC_DIV) % 2) == 0);
    chk3("model_state", state_o, 3'(m_mode));
    chk1("model_rail", pwr_rt_on, (m_mode == 2) || (m_mode == 3));
    chk1("model_ready", ready_o, m_mode == 3);
    chk1("model_fault", fault_o, m_mode == 5);
    chk1("model_a1", pwr_sync_a1, ea1);
    chk1("model_d1", pwr_sync_d1, (m_t0 >= 0) && !ea1);
    chk1("sync_overlap", pwr_sync_a1 & pwr_sync_d1, 1'b0);
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int k;
    rst = 1'b1; en_i = 1'b0; pg_i = 1'b0;
    tickn(2);
    chk3("reset_state", state_o, 3'd0);
    chk1("reset_rail", pwr_rt_on, 1'b0);
    chk1("reset_a1", pwr_sync_a1, 1'b0);
    chk1("reset_fault", fault_o, 1'b0);
    rst = 1'b0;
    tickn(2);

    // Power-up: en_i at cycle 0, pg_i from cycle 30
    en_i = 1'b1;
    for (int c = 0; c < 40 + LAT; c++) begin
      pg_i = (c >= 30);
      tick();
      k = c + 1;
      if (k == 1) begin
        chk1("pu_a1_c1", pwr_sync_a1, 1'b1);
        chk1("pu_d1_c1", pwr_sync_d1, 1'b0);
        chk3("pu_state_c1", state_o, 3'd1);
      end
      if (k == 4)  chk1("pu_a1_c4", pwr_sync_a1, 1'b1);
      if (k == 5)  chk1("pu_a1_c5", pwr_sync_a1, 1'b0);
      if (k == 9)  chk1("pu_a1_c9", pwr_sync_a1, 1'b1);
      if (k == 16) chk1("pu_rail_c16", pwr_rt_on, 1'b0);
      if (k == 17) begin
        chk1("pu_rail_c17", pwr_rt_on, 1'b1);
        chk3("pu_state_c17", state_o, 3'd2);
      end
      if (k == 37 + LAT) chk1("pu_ready_early", ready_o, 1'b0);
      if (k == 38 + LAT) begin
        chk1("pu_ready", ready_o, 1'b1);
        chk3("pu_state_run", state_o, 3'd3);
      end
    end

    // Glitch filter in RUN
    pg_i = 1'b0;
    tickn(7);
    pg_i = 1'b1;
    tickn(10);
    chk3("glitch7_state", state_o, 3'd3);
    pg_i = 1'b0;
    tickn(7 + LAT);
    chk3("glitch_pre8", state_o, 3'd3);
    tick();
    chk3("glitch8_state", state_o, 3'd5);
    chk1("glitch8_fault", fault_o, 1'b1);
    chk1("glitch8_rail", pwr_rt_on, 1'b0);
    en_i = 1'b0;
    tick();
    chk3("fault_clear", state_o, 3'd0);

    // Ramp timeout
    en_i = 1'b1; pg_i = 1'b0;
    tickn(17);
    chk1("to_rail_on", pwr_rt_on, 1'b1);
    tickn(199);
    chk3("to_pre_state", state_o, 3'd2);
    tick();
    chk1("to_fault", fault_o, 1'b1);
    chk1("to_rail_off", pwr_rt_on, 1'b0);
    chk1("to_a1", pwr_sync_a1, 1'b0);
    chk1("to_d1", pwr_sync_d1, 1'b0);
    en_i = 1'b0;
    tick();
    chk3("to_off", state_o, 3'd0);

    // en_i drop on the timeout edge wins
    en_i = 1'b1;
    tickn(17 + 199);
    en_i = 1'b0;
    tick();
    chk3("simul_state", state_o, 3'd4);
    chk1("simul_fault", fault_o, 1'b0);
    chk1("simul_sync", pwr_sync_a1 ^ pwr_sync_d1, 1'b1);
    tickn(15);
    chk3("simul_tail", state_o, 3'd4);
    tick();
    chk3("simul_off", state_o, 3'd0);

    // Orderly shutdown from RUN
    en_i = 1'b1; pg_i = 1'b1;
    tickn(25);
    chk3("sd_run", state_o, 3'd3);
    en_i = 1'b0;
    tick();
    chk1("sd_rail", pwr_rt_on, 1'b0);
    chk1("sd_ready", ready_o, 1'b0);
    en_i = 1'b1;
    tickn(15);
    chk3("sd_tail", state_o, 3'd4);
    chk1("sd_tail_sync", pwr_sync_a1 | pwr_sync_d1, 1'b1);
    tick();
    chk3("sd_off", state_o, 3'd0);
    chk1("sd_a1", pwr_sync_a1, 1'b0);
    chk1("sd_d1", pwr_sync_d1, 1'b0);
    en_i = 1'b0;
    tick();

    // Reset while running cuts everything at once
    en_i = 1'b1;
    tickn(25);
    chk3("rst_pre", state_o, 3'd3);
    rst = 1'b1;
    tick();
    chk3("rst_state", state_o, 3'd0);
    chk1("rst_rail", pwr_rt_on, 1'b0);
    chk1("rst_ready", ready_o, 1'b0);
    chk1("rst_a1", pwr_sync_a1, 1'b0);
    chk1("rst_d1", pwr_sync_d1, 1'b0);
    rst = 1'b0; en_i = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) en_i = !en_i;
      if ($urandom_range(0, 11) == 0) pg_i = !pg_i;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conf_power_sequencer.md
Name: conf_power_sequencer

Overview:
- Power-up/power-down sequencer for the analog board R&T supply rail and its two switching-regulator sync inputs.
- Starts the regulator sync clocks (A1, D1 in anti-phase) before enabling the rail, then waits for power-good.
- Declares the rail ready, or faults on timeout or a power-good drop.
- On shutdown, drops the rail first and keeps the sync clocks running for a tail period.

Parameters:
- SYNC_DIV, 50: half-period of the sync clocks in clk cycles; sync period = 2*SYNC_DIV; minimum 2.
- SYNC_LEAD, 64: cycles the sync clocks run before rail enable; same count applies as the shutdown tail; minimum 1.
- PG_FILT, 8: consecutive pg_i samples needed to accept a level change; minimum 1.
- RAMP_TIMEOUT, 100000: maximum cycles in WAIT_PG before FAULT; must be greater than PG_FILT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en_i  in  1  power request level; 1 = rail on
- pg_i  in  1  regulator power-good; 1 = good
- pwr_rt_on  out  1  R&T rail enable, registered
- pwr_sync_a1  out  1  analog regulator sync clock, registered
- pwr_sync_d1  out  1  digital regulator sync clock, registered
- ready_o  out  1  rail up and stable; high only in RUN
- fault_o  out  1  high only in FAULT
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (rst=1 at an edge): all outputs 0; state OFF; counters 0; sync phase ph=1. Reset mid-operation cuts the rail on the same edge, with no shutdown tail.
- All outputs are flops. They change on the same edge as the state transition that causes them.
- State encoding: OFF=0, SYNC_START=1, WAIT_PG=2, RUN=3, SHUTDOWN=4, FAULT=5.
- OFF
  - Rail 0, sync outputs 0, cnt=0, ph=1.
  - en_i=1 goes to SYNC_START.
- SYNC_START
  - Sync clocks run; rail 0.
  - After SYNC_LEAD cycles in this state, go to WAIT_PG; pwr_rt_on becomes 1 on that edge.
  - en_i=0 goes to SHUTDOWN.
- WAIT_PG
  - Rail 1.
  - Filter counter: +1 for each cycle with pg_i=1; cleared to 0 when pg_i=0.
  - On the edge that samples the PG_FILT-th consecutive high, go to RUN; ready_o=1 on that edge.
  - On reaching RAMP_TIMEOUT cycles in the state without that, go to FAULT.
  - If both happen on the same edge, RUN wins.
  - en_i=0 goes to SHUTDOWN.
- RUN
  - Rail 1; ready_o=1.
  - PG_FILT consecutive pg_i=0 samples go to FAULT; ready_o=0 and pwr_rt_on=0 on that edge.
  - en_i=0 goes to SHUTDOWN.
- SHUTDOWN
  - pwr_rt_on=0 and ready_o=0 on entry edge; sync clocks keep running.
  - After SYNC_LEAD cycles, go to OFF.
  - en_i re-asserting during SHUTDOWN is ignored until OFF is reached.
- FAULT
  - Rail 0; sync outputs 0; fault_o=1.
  - Stays until en_i=0 is sampled, then goes to OFF.
  - A new request needs en_i to go 0 then 1.
- Priority in active states: en_i=0 beats the timeout and the pg-drop fault.
- Sync generator
  - Runs only in SYNC_START, WAIT_PG, RUN and SHUTDOWN.
  - cnt counts 0..SYNC_DIV-1 and wraps; ph toggles on wrap.
  - pwr_sync_a1 = ph; pwr_sync_d1 = ~ph.
  - First running cycle: a1=1, d1=0.
  - Stopped: both 0, cnt=0, ph=1.
  - Duty cycle exactly 50%; edges of a1 and d1 are never coincident with both high.

Optional Feature:
- Macro PWR_PG_SYNC_EN.
- Defined: pg_i passes through a 2-flop synchronizer before the filter. This adds 2 cycles to every pg-driven transition and resets the flops to 0.
- Undefined: pg_i feeds the filter directly; the signal must already be synchronous to clk.

Test Plan (SYNC_DIV=4, SYNC_LEAD=16, PG_FILT=8, RAMP_TIMEOUT=200, macro undefined unless stated):
- Power-up: en_i=1 at cycle 0 -> a1/d1 toggle every 4 cycles in anti-phase from cycle 1. pwr_rt_on rises at cycle 17. pg_i=1 from cycle 30 -> ready_o rises on the edge sampling cycle 37; state_o=3.
- Timeout: pg_i held 0 -> fault_o=1 and pwr_rt_on=0 exactly 200 cycles after rail enable; sync outputs 0. en_i=0 -> state_o=0.
- Glitch filter: in RUN, pg_i low for 7 cycles -> stays RUN. Low for 8 cycles -> FAULT on the 8th.
- Shutdown: en_i=0 in RUN -> pwr_rt_on=0 and ready_o=0 next edge; sync runs 16 more cycles, then both 0, state OFF.
- Simultaneous / reset: en_i=0 on the timeout edge -> SHUTDOWN, fault_o stays 0. rst=1 in RUN -> all outputs 0 next edge.
- PWR_PG_SYNC_EN defined: repeat the power-up case -> ready_o rises 2 cycles later (edge sampling cycle 39).
